// File: rtl/bn_pkg.sv
// Shared definitions for the bn pipeline: default widths, the coefficient
// FSM state encoding and a saturation helper used by bn_stat_coef and bn.
package bn_pkg;

    localparam int BN_DATA_WIDTH = 16;
    localparam int BN_FRAC_BITS  = 8;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        CALC1 = 2'd1,
        CALC2 = 2'd2
    } bn_state_e;

    // Clamp a wide signed value to the signed range of a w-bit result.
    // Callers truncate the returned value to w bits.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/bn_stat_coef_if.sv
// Sample-in / coefficient-out bus of bn_stat_coef.
// Handshake: a sample moves only in a cycle where valid_in and in_ready are
// both high at the rising clock edge; valid_in while in_ready is low is
// ignored and the sample is dropped. coef_valid is a one-cycle pulse with no
// back-pressure; mean_out/range_out/a_out/b_out hold their value between pulses.
interface bn_stat_coef_if #(
    parameter int DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] x_in;
    logic                         valid_in;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] gamma_in;
    logic signed [DATA_WIDTH-1:0] beta_in;
    logic signed [DATA_WIDTH-1:0] mean_out;
    logic        [DATA_WIDTH:0]   range_out;
    logic signed [DATA_WIDTH-1:0] a_out;
    logic signed [DATA_WIDTH-1:0] b_out;
    logic                         coef_valid;

    modport master (
        output x_in, valid_in, gamma_in, beta_in,
        input  in_ready, mean_out, range_out, a_out, b_out, coef_valid
    );

    modport slave (
        input  x_in, valid_in, gamma_in, beta_in,
        output in_ready, mean_out, range_out, a_out, b_out, coef_valid
    );
endinterface

// File: rtl/bn_lod.sv
// Leading-one detector: index of the most significant set bit of range_i.
// Zero and one both map to index 0.
module bn_lod #(
    parameter int W  = 17,
    parameter int KW = $clog2(W)
) (
    input  logic [W-1:0]  range_i,
    output logic [KW-1:0] k_o
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        k_o = '0;
        for (int i = 0; i < W; i++) begin
            if (range_i[i]) k_o = KW'(i);
        end
    end

endmodule

// File: rtl/bn_stat_coef.sv
// Mini-batch statistics and range-BN coefficient generator. Accumulates
// MINI_BATCH samples, then spends two cycles deriving mean/range and the
// a/b coefficients; results appear together with a one-cycle coef_valid.
module bn_stat_coef
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH = BN_DATA_WIDTH,
    parameter int MINI_BATCH = 64,
    parameter int ADDR_WIDTH = $clog2(MINI_BATCH),
    parameter int FRAC_BITS  = BN_FRAC_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    bn_stat_coef_if.slave   bus,
    output bn_state_e       state_o
);

    localparam int SW = DATA_WIDTH + ADDR_WIDTH;   // accumulator width
    localparam int KW = $clog2(DATA_WIDTH + 1);    // leading-one index width

    bn_state_e                    state_q;
    logic [ADDR_WIDTH-1:0]        count_q;
    logic signed [SW-1:0]         sum_q;
    logic signed [DATA_WIDTH-1:0] min_q, max_q;
    logic signed [DATA_WIDTH-1:0] gamma_q, beta_q;
    logic signed [DATA_WIDTH-1:0] mean_q;
    logic        [DATA_WIDTH:0]   range_q;
    logic        [KW-1:0]         k_q;
    logic signed [DATA_WIDTH-1:0] mean_o_q, a_o_q, b_o_q;
    logic        [DATA_WIDTH:0]   range_o_q;
    logic                         coef_valid_q;

    logic                         accept;
    logic                         last;
    logic signed [SW-1:0]         x_ext;
    logic signed [DATA_WIDTH-1:0] mean_d;
    logic        [DATA_WIDTH:0]   range_d;
    logic        [KW-1:0]         k_d;
    logic signed [63:0]           gamma_w, beta_w, a_w, a_ext, mean_ext, prod_w, b_w;
    logic signed [DATA_WIDTH-1:0] a_d, b_d;

    assign accept = bus.valid_in && (state_q == ACC);
    assign last   = (count_q == ADDR_WIDTH'(MINI_BATCH - 1));
    assign x_ext  = {{ADDR_WIDTH{bus.x_in[DATA_WIDTH-1]}}, bus.x_in};

    // First calc stage: floor mean is the top DATA_WIDTH bits of the sum;
    // range widened by one bit so max-min is always representable.
    always_comb begin
        mean_d  = sum_q[ADDR_WIDTH +: DATA_WIDTH];
        range_d = {max_q[DATA_WIDTH-1], max_q} - {min_q[DATA_WIDTH-1], min_q};
    end

    bn_lod #(.W(DATA_WIDTH + 1), .KW(KW)) u_lod (
        .range_i (range_d),
        .k_o     (k_d)
    );

    // Second calc stage: a = gamma scaled by 2^(FRAC_BITS-k), then b = beta - a*mean.
    always_comb begin
        gamma_w = {{(64 - DATA_WIDTH){gamma_q[DATA_WIDTH-1]}}, gamma_q};
        beta_w  = {{(64 - DATA_WIDTH){beta_q[DATA_WIDTH-1]}}, beta_q};
        if (range_q == '0) begin
            a_w = gamma_w;
        end else if (int'(k_q) <= FRAC_BITS) begin
            a_w = gamma_w <<< (FRAC_BITS - int'(k_q));
        end else begin
            a_w = gamma_w >>> (int'(k_q) - FRAC_BITS);
        end
        a_d      = DATA_WIDTH'(sat_to(a_w, DATA_WIDTH));
        a_ext    = {{(64 - DATA_WIDTH){a_d[DATA_WIDTH-1]}}, a_d};
        mean_ext = {{(64 - DATA_WIDTH){mean_q[DATA_WIDTH-1]}}, mean_q};
        prod_w   = a_ext * mean_ext;
        b_w      = beta_w - (prod_w >>> FRAC_BITS);
        b_d      = DATA_WIDTH'(sat_to(b_w, DATA_WIDTH));
    end

    // Batch FSM with accumulator, calc pipeline and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACC;
            count_q      <= '0;
            sum_q        <= '0;
            min_q        <= '0;
            max_q        <= '0;
            gamma_q      <= '0;
            beta_q       <= '0;
            mean_q       <= '0;
            range_q      <= '0;
            k_q          <= '0;
            mean_o_q     <= '0;
            range_o_q    <= '0;
            a_o_q        <= '0;
            b_o_q        <= '0;
            coef_valid_q <= 1'b0;
        end else begin
            coef_valid_q <= 1'b0;
            case (state_q)
                ACC: begin
                    if (accept) begin
                        if (count_q == '0) begin
                            sum_q <= x_ext;
                            min_q <= bus.x_in;
                            max_q <= bus.x_in;
                        end else begin
                            sum_q <= sum_q + x_ext;
                            if (bus.x_in < min_q) min_q <= bus.x_in;
                            if (bus.x_in > max_q) max_q <= bus.x_in;
                        end
                        if (last) begin
                            gamma_q <= bus.gamma_in;
                            beta_q  <= bus.beta_in;
                            count_q <= '0;
                            state_q <= CALC1;
                        end else begin
                            count_q <= count_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                CALC1: begin
                    mean_q  <= mean_d;
                    range_q <= range_d;
                    k_q     <= k_d;
                    state_q <= CALC2;
                end
                CALC2: begin
                    mean_o_q     <= mean_q;
                    range_o_q    <= range_q;
                    a_o_q        <= a_d;
                    b_o_q        <= b_d;
                    coef_valid_q <= 1'b1;
                    state_q      <= ACC;
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == ACC);
    assign bus.mean_out   = mean_o_q;
    assign bus.range_out  = range_o_q;
    assign bus.a_out      = a_o_q;
    assign bus.b_out      = b_o_q;
    assign bus.coef_valid = coef_valid_q;
    assign state_o        = state_q;

endmodule
